// File: rtl/esc_clk_sequencer.sv
// esc_clk_sequencer: ordered bring-up and lock supervision of cascaded MMCM/PLL stages.
// Parameters: N_STAGES (1..4), SYNC_STAGES (>=2), RST_PULSE, HOLDOFF, LOCK_TIMEOUT,
// MAX_RETRY (1..15), HB_DIV.
// Ports:
//   clk_125_in  free-running reference clock
//   rst_n       asynchronous active-low reset
//   locked_in   raw asynchronous lock flags, bit k = stage k
//   fault_clr   single-cycle pulse that leaves FAULT
//   stage_rst   active-high reset per stage
//   sys_rst_n   active-low downstream reset, high only in RUN
//   ready       high only in RUN
//   fault       high only in FAULT
//   cur_stage   stage index being brought up
//   retry_cnt   lock timeouts in the current bring-up
//   heartbeat   RUN-only probe toggle
// Build option: define ESC_SEQ_HEARTBEAT_EN to enable the heartbeat counter;
// without it heartbeat is tied low.
module esc_clk_sequencer #(
   parameter int N_STAGES     = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int RST_PULSE    = 16,
   parameter int HOLDOFF      = 63,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int MAX_RETRY    = 3,
   parameter int HB_DIV       = 21
) (
   input  logic                clk_125_in,
   input  logic                rst_n,
   input  logic [N_STAGES-1:0] locked_in,
   input  logic                fault_clr,
   output logic [N_STAGES-1:0] stage_rst,
   output logic                sys_rst_n,
   output logic                ready,
   output logic                fault,
   output logic [1:0]          cur_stage,
   output logic [3:0]          retry_cnt,
   output logic                heartbeat
);
   localparam int CW = $clog2((RST_PULSE > HOLDOFF ? RST_PULSE : HOLDOFF) + 1);
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);
   localparam logic [1:0] LAST = 2'(N_STAGES - 1);
   typedef enum logic [2:0] {PULSE, WAIT, HOLD, RUN, FAULT} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic [TW-1:0] timer;
   (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0][N_STAGES-1:0] sync_q;
   logic [N_STAGES-1:0] lock_s;
   logic                lock_k, run_loss, up_loss, loss, timeout, to_fault, to_pulse;
   logic [1:0]          run_idx, up_idx, loss_idx, pulse_idx;
   logic [3:0]          retry_nxt;
   always_ff @(posedge clk_125_in or negedge rst_n)
      if (!rst_n)
         sync_q <= '0;
      else
         sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
   assign lock_s = sync_q[SYNC_STAGES-1];
   // Descending scan so the lowest unlocked stage wins; up_* only looks below cur_stage.
   always_comb begin
      run_loss = 1'b0;
      run_idx  = '0;
      up_loss  = 1'b0;
      up_idx   = '0;
      for (int j = N_STAGES - 1; j >= 0; j--)
         if (!lock_s[j]) begin
            run_loss = 1'b1;
            run_idx  = 2'(j);
            if (2'(j) < cur_stage) begin
               up_loss = 1'b1;
               up_idx  = 2'(j);
            end
         end
   end
   assign lock_k    = |(lock_s & (N_STAGES'(1) << cur_stage));
   assign loss      = (state == RUN) ? run_loss : (state == WAIT || state == HOLD) && up_loss;
   assign loss_idx  = (state == RUN) ? run_idx : up_idx;
   assign timeout   = state == WAIT && !lock_k && timer == TW'(LOCK_TIMEOUT - 1);
   assign retry_nxt = retry_cnt + 4'd1;
   assign to_fault  = timeout && !loss && retry_nxt >= 4'(MAX_RETRY);
   assign to_pulse  = loss || (timeout && !to_fault);
   assign pulse_idx = loss ? loss_idx : cur_stage;
   always_ff @(posedge clk_125_in or negedge rst_n) begin
      if (!rst_n) begin
         state     <= PULSE;
         cnt       <= '0;
         timer     <= '0;
         stage_rst <= '1;
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         fault     <= 1'b0;
         cur_stage <= '0;
         retry_cnt <= '0;
      end else if (to_pulse) begin
         // Stages below the target keep running; the target and everything it clocks restart.
         state     <= PULSE;
         cur_stage <= pulse_idx;
         cnt       <= '0;
         stage_rst <= stage_rst | ({N_STAGES{1'b1}} << pulse_idx);
         sys_rst_n <= 1'b0;
         ready     <= 1'b0;
         retry_cnt <= loss ? retry_cnt : retry_nxt;
      end else if (to_fault) begin
         state     <= FAULT;
         stage_rst <= '1;
         fault     <= 1'b1;
         retry_cnt <= retry_nxt;
      end else begin
         case (state)
            PULSE:
               if (cnt == CW'(RST_PULSE - 1)) begin
                  state     <= WAIT;
                  timer     <= '0;
                  stage_rst <= stage_rst & ~(N_STAGES'(1) << cur_stage);
               end else
                  cnt <= cnt + CW'(1);
            WAIT:
               if (lock_k) begin
                  state <= HOLD;
                  cnt   <= '0;
               end else
                  timer <= timer + TW'(1);
            HOLD:
               if (!lock_k) begin
                  state <= WAIT;
                  timer <= '0;
               end else if (cnt == CW'(HOLDOFF - 1)) begin
                  if (cur_stage == LAST) begin
                     state     <= RUN;
                     sys_rst_n <= 1'b1;
                     ready     <= 1'b1;
                     retry_cnt <= '0;
                  end else begin
                     // Next stage has been held in reset since our PULSE; just release it.
                     state     <= WAIT;
                     timer     <= '0;
                     cur_stage <= cur_stage + 2'd1;
                     stage_rst <= stage_rst & ~(N_STAGES'(2) << cur_stage);
                  end
               end else
                  cnt <= cnt + CW'(1);
            RUN: ;
            FAULT:
               if (fault_clr) begin
                  state     <= PULSE;
                  cur_stage <= '0;
                  cnt       <= '0;
                  retry_cnt <= '0;
                  fault     <= 1'b0;
               end
            default: begin
               state     <= FAULT;
               stage_rst <= '1;
               fault     <= 1'b1;
            end
         endcase
      end
   end
`ifdef ESC_SEQ_HEARTBEAT_EN
   logic [HB_DIV-1:0] hb_cnt;
   always_ff @(posedge clk_125_in or negedge rst_n)
      if (!rst_n) begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end else if (state == RUN && !loss) begin
         hb_cnt <= hb_cnt + HB_DIV'(1);
         if (&hb_cnt)
            heartbeat <= ~heartbeat;
      end else begin
         hb_cnt    <= '0;
         heartbeat <= 1'b0;
      end
`else
   // HB_DIV is never negative, so this is a constant 0.
   assign heartbeat = (HB_DIV < 0);
`endif
endmodule

// File: tb/tb_esc_clk_sequencer.sv
// tb_esc_clk_sequencer: directed-random bench for esc_clk_sequencer against a latency model.
module tb_esc_clk_sequencer;
   localparam int N = 2, SYNC = 2, PULSE_LEN = 4, HOLD_LEN = 8, TMO = 100, RETRIES = 2, HBD = 4;
`ifdef ESC_SEQ_HEARTBEAT_EN
   localparam logic HB = 1'b1;
`else
   localparam logic HB = 1'b0;
`endif
   // Raw lock rising to FSM reaction, and to the next release when HOLD runs clean.
   localparam int LOCK_LAT   = SYNC + 1;
   localparam int ADV        = LOCK_LAT + HOLD_LEN;
   // Lock already synchronised when WAIT is entered: one WAIT cycle then HOLD.
   localparam int ADV_SYNCED = 1 + HOLD_LEN;
   localparam int HB_PERIOD  = 1 << HBD;
   localparam int SR0 = 0, SR1 = 1, SYS = 2, RT0 = 3, FLT = 4;
   logic         clk = 1'b0, rst_n = 1'b0, fault_clr = 1'b0;
   logic [N-1:0] locked_in = '0;
   logic [N-1:0] stage_rst;
   logic         sys_rst_n, ready, fault, heartbeat;
   logic [1:0]   cur_stage;
   logic [3:0]   retry_cnt;
   int           tests = 0, failed = 0;
   esc_clk_sequencer #(
      .N_STAGES(N), .SYNC_STAGES(SYNC), .RST_PULSE(PULSE_LEN), .HOLDOFF(HOLD_LEN),
      .LOCK_TIMEOUT(TMO), .MAX_RETRY(RETRIES), .HB_DIV(HBD)
   ) dut (
      .clk_125_in(clk), .rst_n(rst_n), .locked_in(locked_in), .fault_clr(fault_clr),
      .stage_rst(stage_rst), .sys_rst_n(sys_rst_n), .ready(ready), .fault(fault),
      .cur_stage(cur_stage), .retry_cnt(retry_cnt), .heartbeat(heartbeat)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   function automatic logic probe(input int sel);
      return sel == SR0 ? stage_rst[0] : sel == SR1 ? stage_rst[1] : sel == SYS ? sys_rst_n :
             sel == RT0 ? retry_cnt[0] : fault;
   endfunction
   // Counts edges until the probed signal takes val; an expired bound returns bound.
   task automatic wait_for(input int sel, input logic val, input int bound, output int n);
      n = 0;
      while (probe(sel) !== val && n < bound) begin
         step(1);
         n++;
      end
   endtask
   task automatic chk_reset_outputs(input string tag);
      chk({tag, " stage_rst"}, stage_rst, 2'b11);
      chk({tag, " sys_rst_n"}, sys_rst_n, 0);
      chk({tag, " ready"}, ready, 0);
      chk({tag, " fault"}, fault, 0);
      chk({tag, " cur_stage"}, cur_stage, 0);
      chk({tag, " retry_cnt"}, retry_cnt, 0);
      chk({tag, " heartbeat"}, heartbeat, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int n, d, g;
      // Reset state.
      step(3);
      chk_reset_outputs("reset");
      // Nominal bring-up, lock 10 cycles after each release.
      rst_n = 1'b1;
      wait_for(SR0, 1'b0, 50, n);
      chk("nom pulse0 len", n, PULSE_LEN);
      chk("nom sr1 held", stage_rst[1], 1);
      step(10);
      locked_in[0] = 1'b1;
      wait_for(SR1, 1'b0, 200, n);
      chk("nom stage1 release", n, ADV);
      chk("nom cur_stage 1", cur_stage, 1);
      chk("nom sys still low", sys_rst_n, 0);
      step(10);
      locked_in[1] = 1'b1;
      wait_for(SYS, 1'b1, 200, n);
      chk("nom sys_rst_n rise", n, ADV);
      chk("nom ready", ready, 1);
      chk("nom run cur_stage", cur_stage, N - 1);
      chk("nom retry", retry_cnt, 0);
      // Heartbeat in RUN.
      step(HB_PERIOD - 1);
      chk("hb before first toggle", heartbeat, 0);
      step(1);
      chk("hb first toggle", heartbeat, HB);
      step(HB_PERIOD);
      chk("hb second toggle", heartbeat, 0);
      step(HB_PERIOD);
      chk("hb third toggle", heartbeat, HB);
      // Lock loss in RUN, then full re-sequence with a glitch during stage 1 HOLD.
      locked_in = '0;
      wait_for(SYS, 1'b0, 50, n);
      chk("loss sys_rst_n fall", n, LOCK_LAT);
      chk("loss stage_rst", stage_rst, 2'b11);
      chk("loss ready", ready, 0);
      chk("loss hb cleared", heartbeat, 0);
      chk("loss cur_stage", cur_stage, 0);
      chk("loss retry", retry_cnt, 0);
      wait_for(SR0, 1'b0, 50, n);
      chk("reseq pulse0 len", n, PULSE_LEN);
      d = $urandom_range(2, 30);
      step(d);
      locked_in[0] = 1'b1;
      wait_for(SR1, 1'b0, 200, n);
      chk("reseq stage1 release", n, ADV);
      d = $urandom_range(2, 30);
      g = $urandom_range(1, HOLD_LEN - 1);
      step(d);
      locked_in[1] = 1'b1;
      step(g);
      locked_in[1] = 1'b0;
      step(1);
      locked_in[1] = 1'b1;
      wait_for(SYS, 1'b1, 200, n);
      chk("glitch delayed run", g + 1 + n, ADV + g + 1);
      chk("glitch retry", retry_cnt, 0);
      // fault_clr outside FAULT is ignored.
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      step(2);
      chk("clr ignored ready", ready, 1);
      chk("clr ignored fault", fault, 0);
      // Timeouts on stage 1 into FAULT.
      locked_in = '0;
      wait_for(SYS, 1'b0, 50, n);
      chk("tmo loss", n, LOCK_LAT);
      wait_for(SR0, 1'b0, 50, n);
      d = $urandom_range(2, 30);
      step(d);
      locked_in[0] = 1'b1;
      wait_for(SR1, 1'b0, 200, n);
      chk("tmo stage1 release", n, ADV);
      wait_for(RT0, 1'b1, TMO + 50, n);
      chk("tmo first timeout", n, TMO);
      chk("tmo repulse stage_rst", stage_rst, 2'b10);
      chk("tmo cur_stage", cur_stage, 1);
      chk("tmo not fault", fault, 0);
      wait_for(SR1, 1'b0, 50, n);
      chk("tmo repulse len", n, PULSE_LEN);
      wait_for(FLT, 1'b1, TMO + 50, n);
      chk("tmo second timeout", n, TMO);
      chk("fault retry", retry_cnt, RETRIES);
      chk("fault stage_rst", stage_rst, 2'b11);
      chk("fault sys_rst_n", sys_rst_n, 0);
      step(5);
      chk("fault sticky", fault, 1);
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      chk("clr fault", fault, 0);
      chk("clr retry", retry_cnt, 0);
      chk("clr cur_stage", cur_stage, 0);
      chk("clr stage_rst", stage_rst, 2'b11);
      wait_for(SR0, 1'b0, 50, n);
      chk("clr pulse0 len", n, PULSE_LEN);
      wait_for(SR1, 1'b0, 200, n);
      chk("clr synced stage1 release", n, ADV_SYNCED);
      // Upstream loss while waiting on stage 1.
      locked_in[0] = 1'b0;
      wait_for(SR0, 1'b1, 50, n);
      chk("upstream loss latency", n, LOCK_LAT);
      chk("upstream cur_stage", cur_stage, 0);
      chk("upstream retry", retry_cnt, 0);
      locked_in[0] = 1'b1;
      wait_for(SR0, 1'b0, 50, n);
      chk("upstream pulse0 len", n, PULSE_LEN);
      wait_for(SR1, 1'b0, 200, n);
      chk("upstream stage1 release", n, ADV_SYNCED);
      // Asynchronous reset in stage 1 HOLD.
      locked_in[1] = 1'b1;
      step(LOCK_LAT + 3);
      chk("pre-reset stage_rst", stage_rst, 2'b00);
      chk("pre-reset cur_stage", cur_stage, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("async");
      step(2);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
